// File: rtl/kat_adc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : kat_adc_config_sequencer
// Brief    : Power-up configuration sequencer for one KAT ADC channel. Pulses
//            the ADC reset, waits a settle interval, replays a table of 3-wire
//            register writes through the serial engine's start/done handshake,
//            optionally steps the capture MMCM phase, then reports done/error.
// Revision : 1.0 - initial release
// ============================================================================
module kat_adc_config_sequencer #(
  parameter int           NUM_WRITES    = 4,
  parameter logic [159:0] INIT_TABLE    = 160'h0,
  parameter int           RESET_CYCLES  = 16,
  parameter int           SETTLE_CYCLES = 256,
  parameter int           PS_STEPS      = 0,
  parameter int           PS_INC        = 1,
  parameter int           ACK_TIMEOUT   = 8,
  parameter int           DONE_TIMEOUT  = 1023
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        go,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [2:0]  err_index,
  output logic        adc_reset,
  output logic        cfg_start,
  output logic [3:0]  cfg_addr,
  output logic [15:0] cfg_data,
  input  logic        cfg_done,
  output logic        psen,
  output logic        psincdec,
  input  logic        psdone
);

  // One shared interval/timeout counter, sized for the longest interval.
  localparam int MAX_RS  = (RESET_CYCLES > SETTLE_CYCLES) ? RESET_CYCLES : SETTLE_CYCLES;
  localparam int MAX_AD  = (ACK_TIMEOUT > DONE_TIMEOUT) ? ACK_TIMEOUT : DONE_TIMEOUT;
  localparam int MAX_CNT = (MAX_RS > MAX_AD) ? MAX_RS : MAX_AD;
  localparam int CNT_W   = $clog2(MAX_CNT + 1);
  localparam int STEP_W  = (PS_STEPS > 0) ? $clog2(PS_STEPS + 1) : 1;

  // Counter values on which each interval or timeout expires.
  localparam logic [CNT_W-1:0]  RESET_LAST  = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  ACK_LAST    = CNT_W'(ACK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  DONE_LAST   = CNT_W'(DONE_TIMEOUT - 1);
  localparam logic [2:0]        LAST_IDX    = 3'(NUM_WRITES - 1);
  localparam logic [STEP_W-1:0] STEP_LAST   = STEP_W'(PS_STEPS - 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_RESET    = 4'd1,
    S_SETTLE   = 4'd2,
    S_ISSUE    = 4'd3,
    S_ACKWAIT  = 4'd4,
    S_DONEWAIT = 4'd5,
    S_PSREQ    = 4'd6,
    S_PSWAIT   = 4'd7,
    S_FAIL     = 4'd8
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        index_q, index_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic [2:0]        err_index_q, err_index_d;
  logic              adc_reset_q, adc_reset_d;
  logic              cfg_start_q, cfg_start_d;
  logic [3:0]        cfg_addr_q, cfg_addr_d;
  logic [15:0]       cfg_data_q, cfg_data_d;
  logic              psen_q, psen_d;
  logic              psincdec_q, psincdec_d;

  logic [19:0]       entry_sel;
  logic [CNT_W-1:0]  cnt_inc;
  logic [2:0]        step_lsb;

  assign entry_sel = INIT_TABLE[20*index_q +: 20];
  assign cnt_inc   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;

  // Phase failures report the low three bits of the step number.
  if (STEP_W >= 3) begin : g_step_wide
    assign step_lsb = step_q[2:0];
  end else begin : g_step_narrow
    assign step_lsb = {{(3-STEP_W){1'b0}}, step_q};
  end

  // Next-state and registered-output logic for the sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_inc;
    index_d     = index_q;
    step_d      = step_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    adc_reset_d = adc_reset_q;
    cfg_start_d = 1'b0;
    cfg_addr_d  = cfg_addr_q;
    cfg_data_d  = cfg_data_q;
    psen_d      = 1'b0;
    psincdec_d  = psincdec_q;

    case (state_q)
      S_IDLE: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        if (go) begin
          done_d      = 1'b0;
          error_d     = 1'b0;
          err_index_d = 3'd0;
          busy_d      = 1'b1;
          adc_reset_d = 1'b1;
          state_d     = S_RESET;
        end
      end

      S_RESET: begin
        if (cnt_q == RESET_LAST) begin
          adc_reset_d = 1'b0;
          cnt_d       = '0;
          state_d     = S_SETTLE;
        end
      end

      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          index_d = 3'd0;
          cnt_d   = '0;
          state_d = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (cfg_done) begin
          cfg_addr_d  = entry_sel[19:16];
          cfg_data_d  = entry_sel[15:0];
          cfg_start_d = 1'b1;
          cnt_d       = '0;
          state_d     = S_ACKWAIT;
        end
      end

      S_ACKWAIT: begin
        if (!cfg_done) begin
          cnt_d   = '0;
          state_d = S_DONEWAIT;
        end else if (cnt_q == ACK_LAST) begin
          err_index_d = index_q;
          cnt_d       = '0;
          state_d     = S_FAIL;
        end
      end

      S_DONEWAIT: begin
        if (cfg_done) begin
          cnt_d = '0;
          if (index_q == LAST_IDX) begin
            if (PS_STEPS > 0) begin
              step_d  = '0;
              state_d = S_PSREQ;
            end else begin
              done_d  = 1'b1;
              busy_d  = 1'b0;
              state_d = S_IDLE;
            end
          end else begin
            index_d = index_q + 3'd1;
            state_d = S_ISSUE;
          end
        end else if (cnt_q == DONE_LAST) begin
          err_index_d = index_q;
          cnt_d       = '0;
          state_d     = S_FAIL;
        end
      end

      S_PSREQ: begin
        psen_d     = 1'b1;
        psincdec_d = (PS_INC != 0);
        cnt_d      = '0;
        state_d    = S_PSWAIT;
      end

      S_PSWAIT: begin
        if (psdone) begin
          cnt_d = '0;
          if (step_q == STEP_LAST) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            step_d  = step_q + 1'b1;
            state_d = S_PSREQ;
          end
        end else if (cnt_q == DONE_LAST) begin
          err_index_d = step_lsb;
          cnt_d       = '0;
          state_d     = S_FAIL;
        end
      end

      S_FAIL: begin
        error_d = 1'b1;
        busy_d  = 1'b0;
        cnt_d   = '0;
        state_d = S_IDLE;
      end

      default: begin
        busy_d      = 1'b0;
        adc_reset_d = 1'b0;
        cnt_d       = '0;
        state_d     = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset drops every request immediately.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      index_q     <= 3'd0;
      step_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      err_index_q <= 3'd0;
      adc_reset_q <= 1'b0;
      cfg_start_q <= 1'b0;
      cfg_addr_q  <= 4'd0;
      cfg_data_q  <= 16'd0;
      psen_q      <= 1'b0;
      psincdec_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      index_q     <= index_d;
      step_q      <= step_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      adc_reset_q <= adc_reset_d;
      cfg_start_q <= cfg_start_d;
      cfg_addr_q  <= cfg_addr_d;
      cfg_data_q  <= cfg_data_d;
      psen_q      <= psen_d;
      psincdec_q  <= psincdec_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign err_index = err_index_q;
  assign adc_reset = adc_reset_q;
  assign cfg_start = cfg_start_q;
  assign cfg_addr  = cfg_addr_q;
  assign cfg_data  = cfg_data_q;
  assign psen      = psen_q;
  assign psincdec  = psincdec_q;

endmodule
`default_nettype wire

// File: tb/tb_kat_adc_config_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_kat_adc_config_sequencer
// Brief    : Self-checking bench for kat_adc_config_sequencer with a reactive
//            3-wire engine model and an MMCM phase-shift responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_kat_adc_config_sequencer;

  localparam int RC = 16;
  localparam int SC = 20;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic        busy, done, error, adc_reset, cfg_start, psen, psincdec;
  logic [2:0]  err_index;
  logic [3:0]  cfg_addr;
  logic [15:0] cfg_data;
  logic        cfg_done;
  logic        psdone = 1'b0;

  always #5 clk = ~clk;

  kat_adc_config_sequencer #(
    .NUM_WRITES   (2),
    .INIT_TABLE   ({120'h0, 20'h2BEEF, 20'h10123}),
    .RESET_CYCLES (RC),
    .SETTLE_CYCLES(SC),
    .PS_STEPS     (3),
    .PS_INC       (0),
    .ACK_TIMEOUT  (8),
    .DONE_TIMEOUT (64)
  ) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .go       (go),
    .busy     (busy),
    .done     (done),
    .error    (error),
    .err_index(err_index),
    .adc_reset(adc_reset),
    .cfg_start(cfg_start),
    .cfg_addr (cfg_addr),
    .cfg_data (cfg_data),
    .cfg_done (cfg_done),
    .psen     (psen),
    .psincdec (psincdec),
    .psdone   (psdone)
  );

  // Engine model: mode 0 normal, 1 ignores starts, 3 never finishes addr 2.
  int         eng_mode  = 0;
  bit         force_low = 1'b0;
  bit         eng_act   = 1'b0;
  int         eng_cnt   = 0;
  logic [3:0] eng_addr  = 4'd0;

  assign cfg_done = !(eng_act && eng_cnt >= 1) && !force_low;

  always @(negedge clk) begin
    if (cfg_start && eng_mode != 1) begin
      eng_act  <= 1'b1;
      eng_cnt  <= 0;
      eng_addr <= cfg_addr;
    end else if (eng_act) begin
      if (eng_cnt >= 41 && !(eng_mode == 3 && eng_addr == 4'h2)) eng_act <= 1'b0;
      else eng_cnt <= eng_cnt + 1;
    end
  end

  // Phase-shift responder: psdone pulse 5 clocks after each psen.
  bit ps_respond = 1'b1;
  int ps_cnt     = 0;

  always @(negedge clk) begin
    psdone <= 1'b0;
    if (psen && ps_respond) ps_cnt <= 5;
    else if (ps_cnt != 0) begin
      ps_cnt <= ps_cnt - 1;
      if (ps_cnt == 1) psdone <= 1'b1;
    end
  end

  // Monitors: write requests and phase-shift pulses.
  int          start_cnt = 0;
  int          psen_cnt  = 0;
  int          psinc_bad = 0;
  logic [3:0]  log_addr [0:63];
  logic [15:0] log_data [0:63];

  always @(negedge clk) begin
    if (cfg_start) begin
      if (start_cnt < 64) begin
        log_addr[start_cnt] <= cfg_addr;
        log_data[start_cnt] <= cfg_data;
      end
      start_cnt <= start_cnt + 1;
    end
    if (psen) begin
      psen_cnt <= psen_cnt + 1;
      if (psincdec !== 1'b0) psinc_bad <= psinc_bad + 1;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic pulse_go();
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"},      int'(busy),      0);
    check({tag, "_done"},      int'(done),      0);
    check({tag, "_error"},     int'(error),     0);
    check({tag, "_err_index"}, int'(err_index), 0);
    check({tag, "_adc_reset"}, int'(adc_reset), 0);
    check({tag, "_cfg_start"}, int'(cfg_start), 0);
    check({tag, "_psen"},      int'(psen),      0);
    check({tag, "_cfg_addr"},  int'(cfg_addr),  0);
    check({tag, "_cfg_data"},  int'(cfg_data),  0);
    check({tag, "_psincdec"},  int'(psincdec),  0);
  endtask

  typedef struct {
    int mode;
    bit respond;
    int e_done;
    int e_err;
    int e_idx;
    int e_starts;
    int e_psen;
  } vec_t;

  vec_t vt [4];

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int sb, pb, bb, n, m;

    // {engine mode, psdone responds, done, error, err_index, starts, psen}
    vt[0] = '{0, 1'b1, 1, 0, 0, 2, 3};  // full sequence with phase steps
    vt[1] = '{1, 1'b1, 0, 1, 0, 1, 0};  // engine never acknowledges
    vt[2] = '{0, 1'b0, 0, 1, 0, 2, 1};  // psdone never returns on step 0
    vt[3] = '{3, 1'b1, 0, 1, 1, 2, 0};  // second write never completes

    rst = 1'b1;
    go  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("rst_release");

    // Start-up timing, table contents and completion flags.
    sb = start_cnt; pb = psen_cnt; bb = psinc_bad;
    @(negedge clk) go = 1'b1;
    @(negedge clk) go = 1'b0;
    check("go_busy", int'(busy), 1);
    check("go_adc_reset", int'(adc_reset), 1);
    n = 0;
    while (adc_reset === 1'b1 && n < 1000) begin n++; @(negedge clk); end
    check("adc_reset_width", n, RC);
    m = 0;
    while (cfg_start !== 1'b1 && m < 1000) begin m++; @(negedge clk); end
    check("settle_to_start", m, SC + 1);
    check("first_addr", int'(cfg_addr), 32'h1);
    check("first_data", int'(cfg_data), 32'h0123);
    wait_idle(3000);
    check("done_with_busy_fall", int'(done), 1);
    check("run1_error", int'(error), 0);
    check("run1_starts", start_cnt - sb, 2);
    check("second_addr", int'(log_addr[sb + 1]), 32'h2);
    check("second_data", int'(log_data[sb + 1]), 32'hBEEF);
    check("run1_psen", psen_cnt - pb, 3);
    check("run1_psincdec", psinc_bad - bb, 0);

    // Scenario table.
    for (int i = 0; i < 4; i++) begin
      eng_mode   = vt[i].mode;
      ps_respond = vt[i].respond;
      sb = start_cnt; pb = psen_cnt;
      pulse_go();
      wait_idle(3000);
      check($sformatf("vec%0d_done", i),      int'(done),      vt[i].e_done);
      check($sformatf("vec%0d_error", i),     int'(error),     vt[i].e_err);
      check($sformatf("vec%0d_err_index", i), int'(err_index), vt[i].e_idx);
      check($sformatf("vec%0d_starts", i),    start_cnt - sb,  vt[i].e_starts);
      check($sformatf("vec%0d_psen", i),      psen_cnt - pb,   vt[i].e_psen);
      eng_mode   = 0;
      ps_respond = 1'b1;
      repeat (60) @(negedge clk);
    end

    // go during DONEWAIT is ignored; a later go reruns the sequence.
    sb = start_cnt; pb = psen_cnt;
    pulse_go();
    n = 0;
    while (cfg_done !== 1'b0 && n < 1000) begin n++; @(negedge clk); end
    go = 1'b1;
    @(negedge clk) go = 1'b0;
    wait_idle(3000);
    check("busy_go_done", int'(done), 1);
    check("busy_go_starts", start_cnt - sb, 2);
    check("busy_go_psen", psen_cnt - pb, 3);
    sb = start_cnt;
    pulse_go();
    check("rego_done_clear", int'(done), 0);
    check("rego_busy", int'(busy), 1);
    wait_idle(3000);
    check("rego_done", int'(done), 1);
    check("rego_starts", start_cnt - sb, 2);

    // Reset in ACKWAIT clears outputs at once and stays idle afterwards.
    sb = start_cnt;
    pulse_go();
    n = 0;
    while (cfg_start !== 1'b1 && n < 1000) begin n++; @(negedge clk); end
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk) rst = 1'b0;
    repeat (100) @(negedge clk);
    check("post_rst_starts", start_cnt - sb, 1);
    check("post_rst_busy", int'(busy), 0);

    // cfg_done held low at ISSUE entry; start follows release by one clock.
    force_low = 1'b1;
    sb = start_cnt;
    pulse_go();
    repeat (RC + SC + 100) @(negedge clk);
    check("held_no_start", start_cnt - sb, 0);
    check("held_busy", int'(busy), 1);
    force_low = 1'b0;
    @(negedge clk);
    check("start_after_release", int'(cfg_start), 1);
    wait_idle(3000);
    check("held_done", int'(done), 1);
    check("held_error", int'(error), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/kat_adc_config_sequencer.md
# kat_adc_config_sequencer

Autonomous power-up configuration sequencer for one KAT ADC channel. On a `go` pulse it pulses the ADC reset, waits a settle interval, and replays a parameterised table of 3-wire register writes through the existing serial configuration engine using its start/done handshake. It then optionally steps the capture MMCM phase a fixed number of times and reports done or error. It sits between the software-visible Wishbone controller and that controller's per-ADC 3-wire engine and MMCM phase-shift port, so bring-up needs no software sequencing.

## Interface
Parameters:
- `NUM_WRITES`, 4 — table entries replayed, 1..8.
- `INIT_TABLE`, 160'h0 — 8 packed entries of 20 bits `{addr[3:0], data[15:0]}`; entry i occupies bits [20i+19:20i]; entry 0 is sent first.
- `RESET_CYCLES`, 16 — `adc_reset` high time in clocks, ≥1.
- `SETTLE_CYCLES`, 256 — wait after reset release, ≥1.
- `PS_STEPS`, 0 — MMCM phase steps after the table; 0 skips the phase stage.
- `PS_INC`, 1 — `psincdec` value driven for every step.
- `ACK_TIMEOUT`, 8 — max clocks for `cfg_done` to fall after `cfg_start`.
- `DONE_TIMEOUT`, 1023 — max clocks for `cfg_done` to rise again; also the `psdone` limit.

Ports:
- `wb_clk_i` in 1 — sole clock; also the MMCM phase-shift clock.
- `wb_rst_i` in 1 — asynchronous, active-high reset.
- `go` in 1 — start pulse; ignored unless state is IDLE.
- `busy` out 1 — high in every state except IDLE.
- `done` out 1 — sticky success flag; cleared by `go` or reset.
- `error` out 1 — sticky timeout flag; cleared by `go` or reset.
- `err_index` out 3 — table index, or phase step number, where the timeout occurred.
- `adc_reset` out 1 — ADC reset request.
- `cfg_start` out 1 — one-cycle write request to the serial engine.
- `cfg_addr` out 4 — register address, held stable from `cfg_start` until the next issue.
- `cfg_data` out 16 — register data, same hold rule as `cfg_addr`.
- `cfg_done` in 1 — serial engine idle (1 = idle).
- `psen` out 1 — one-cycle phase-shift enable.
- `psincdec` out 1 — phase-shift direction.
- `psdone` in 1 — MMCM phase-shift completion pulse.

## Operation
- States: IDLE, RESET, SETTLE, ISSUE, ACKWAIT, DONEWAIT, PSREQ, PSWAIT, FAIL.
- IDLE: on `go`, clear `done`, `error` and `err_index`, load the reset counter, go to RESET.
- RESET: `adc_reset`=1 for RESET_CYCLES clocks, then go to SETTLE.
- SETTLE: count SETTLE_CYCLES, set index=0, go to ISSUE.
- ISSUE: wait for `cfg_done`=1. Then drive `cfg_addr`/`cfg_data` from entry[index], pulse `cfg_start` for one cycle, go to ACKWAIT.
- ACKWAIT: on `cfg_done`=0, go to DONEWAIT. If ACK_TIMEOUT clocks elapse with `cfg_done` still 1, go to FAIL.
- DONEWAIT: on `cfg_done`=1, advance.
  - If index==NUM_WRITES-1: go to PSREQ when PS_STEPS>0, otherwise finish.
  - Else index+1, go to ISSUE.
  - If DONE_TIMEOUT clocks elapse first, go to FAIL.
- PSREQ: `psen`=1 for one cycle with `psincdec`=PS_INC, go to PSWAIT.
- PSWAIT: on `psdone`=1, step+1; if step==PS_STEPS finish, else go to PSREQ. Timeout after DONE_TIMEOUT clocks, go to FAIL.
- Finish: set `done`=1, go to IDLE.
- FAIL: set `error`=1, latch `err_index` (3 LSBs of the step count for phase failures), go to IDLE.
- Counters saturate; none wraps. The timeout counter clears on every state entry.
- `psdone` arriving outside PSWAIT is ignored.
- `go` while busy is ignored; it has no restart effect.

## Timing
- Reset values: state IDLE, `busy` `done` `error` `adc_reset` `cfg_start` `psen` = 0, `err_index`=0, `cfg_addr`=0, `cfg_data`=0, `psincdec`=0.
- Asserting `wb_rst_i` mid-sequence returns to IDLE immediately and drops `adc_reset`/`cfg_start`/`psen` the same instant. A write already inside the engine runs to completion; the sequencer does not track it.
- `go` sampled at edge N: `busy` and `adc_reset` are 1 from N+1. `adc_reset` falls at N+1+RESET_CYCLES.
- First `cfg_start` = SETTLE_CYCLES+1 clocks after `adc_reset` falls, provided `cfg_done`=1.
- Back-to-back writes: the next `cfg_start` comes no earlier than 2 clocks after `cfg_done` rises.
- `done`/`error` rise in the same cycle `busy` falls. `busy` falls the cycle after the final `cfg_done` rise, or after the final `psdone`.
- All outputs are registered.

## Test plan
- NUM_WRITES=2, table {0x1,0x0123},{0x2,0xBEEF}, engine model drops done 2 clocks after start and holds it low 40 clocks -> `adc_reset` 16 clocks; two `cfg_start` pulses with addr/data 0x1/0x0123 then 0x2/0xBEEF; `done`=1, `error`=0.
- Engine model never drops `cfg_done` -> FAIL after 8 clocks, `error`=1, `err_index`=0, no second `cfg_start`.
- PS_STEPS=3, PS_INC=0, `psdone` returned 5 clocks after each `psen` -> exactly 3 `psen` pulses with `psincdec`=0, then `done`=1.
- `go` pulsed during DONEWAIT -> ignored, sequence completes unchanged. Second `go` after `done` -> `done` clears and the full sequence repeats.
- `wb_rst_i` asserted during ACKWAIT -> all outputs at reset values immediately; no `cfg_start` until a new `go`.
- `cfg_done` held 0 when ISSUE is entered, released after 100 clocks -> `cfg_start` fires 1 clock after release; no error flagged.
